dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the byte address width (512-byte space).
REQ-003 SHALL have port clk, input, 1, the single clock; every state change occurs on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, MEM-stage access request.
REQ-006 SHALL have port req_ready, output, 1, bridge can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RV32I load/store funct3.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-010 SHALL have port req_wdata, input, DATA_W, store data (low bytes used for SB/SH).
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle load-data-valid pulse.
REQ-012 SHALL have port rsp_rdata, output, DATA_W, extended load result, valid when rsp_valid=1.
REQ-013 SHALL have port err, output, 1, one-cycle pulse flagging a rejected access.

Function
REQ-014 SHALL hold a word array of 2**ADDR_W/4 words, indexed by req_addr[ADDR_W-1:2].
REQ-015 SHALL implement FSM states IDLE, READ, RESP; a request is accepted on an edge where req_valid && req_ready.
REQ-016 SHALL drive req_ready=1 in IDLE and RESP, 0 in READ.
REQ-017 SHALL commit an accepted store at the accepting edge with byte enables: SB (000) 1 lane, SH (001) 2 lanes, SW (010) 4 lanes; the state remains/returns IDLE; no rsp_valid.
REQ-018 SHALL on an accepted load go to READ; in READ read the array and register the extended result; then go to RESP with rsp_valid=1 for exactly one cycle (load latency 2 cycles from acceptance).
REQ-019 SHALL in RESP accept a new request (back-to-back); without req_valid, RESP returns to IDLE.
REQ-020 SHALL extend loads: LB (000) sign-extend byte, LH (001) sign-extend half, LW (010) word, LBU (100) zero-extend byte, LHU (101) zero-extend half; lane selected by req_addr[1:0].
REQ-021 SHALL treat any other funct3 (loads 011/110/111, stores 011-111) as illegal: no write, err pulse on the cycle after acceptance, loads still respond with rsp_rdata=0.
REQ-022 SHALL return new data for a load accepted on the cycle after a store to the same word (read-after-write).
REQ-023 SHALL hold rsp_rdata stable between responses.

Reset
REQ-024 SHALL on reset drive state=IDLE, req_ready=1 the cycle after reset, rsp_valid=0, rsp_rdata=0, err=0.
REQ-025 SHALL on reset during READ/RESP drop the pending load with no rsp_valid; array contents are not cleared.

Configuration
REQ-026 SHALL with DMEM_MISALIGN_TRAP_EN defined reject misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0): no write, err pulse, load rsp_rdata=0.
REQ-027 SHALL without DMEM_MISALIGN_TRAP_EN force-align misaligned addresses (clear addr[0] for half, addr[1:0] for word) and never raise err for alignment.

Structure
REQ-028 SHALL place funct3 constants (LB..LHU, SB..SW) and the FSM state enum in package dmem_pkg.
REQ-029 SHALL implement the byte-enabled word storage as sub-module dmem_array (write port with 4-bit byte enable, registered read).

Verification
REQ-030 SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_valid exactly 2 cycles after load acceptance, rsp_rdata=0xDEADBEEF.
REQ-031 SB 0x80 @0x021, LB @0x021 -> 0xFFFFFF80; LBU @0x021 -> 0x00000080; LH @0x020 -> 0xFFFF8000 (word previously 0).
REQ-032 Load accepted in RESP of a prior load -> two consecutive responses, req_ready=0 only in READ cycles.
REQ-033 LW @0x013: with macro -> err=1, rsp_rdata=0; without macro -> data of word @0x010, err=0.
REQ-034 Reset asserted in READ -> no rsp_valid, req_ready=1 next cycle; subsequent LW @0x010 still returns 0xDEADBEEF.
REQ-035 Store funct3=011 @0x030 -> err pulse, LW @0x030 returns prior contents unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM state type and access helpers for dmem_bridge
//
// Contents:
//   F3_*        RV32I load/store funct3 encodings
//   state_t     bridge FSM states (IDLE, READ, RESP)
//   load_legal  funct3 is a supported load
//   store_legal funct3 is a supported store
//   misaligned  half access with addr[0]=1 or word access with addr[1:0]!=0
//   align_off   byte offset forced onto the natural boundary of the access size
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic load_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-enabled word storage with registered read port
//
// Ports:
//   clk    clock
//   we     write enable; lanes selected by be are written at the rising edge
//   be     4-bit byte-lane enable, bit i covers wdata lane i
//   waddr  word index for writes
//   wdata  write data (already replicated onto the enabled lanes)
//   re     read enable; rdata is loaded from raddr at the rising edge
//   raddr  word index for reads
//   rdata  registered read data, holds until the next read
module dmem_array #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 7
) (
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               re,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  localparam int LANE_W = DATA_W / 4;

  logic [DATA_W-1:0] mem [0:(2**DEPTH_W)-1];

  // Contents are deliberately left unreset so a reset never wipes memory.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - MEM-stage load/store bridge onto a byte-enabled data array
//
// Optional feature: define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses;
// otherwise misaligned addresses are silently forced onto the access boundary.
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   req_valid   access request from the MEM stage
//   req_ready   bridge accepts a request this cycle (low only while reading)
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I load/store funct3
//   req_addr    byte address
//   req_wdata   store data, low bytes used for SB/SH
//   rsp_valid   one-cycle pulse, load result valid
//   rsp_rdata   extended load result, held between responses
//   err         one-cycle pulse on the cycle after a rejected access is accepted
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err
);

  localparam int LANE_W  = DATA_W / 4;
  localparam int HALF_W  = DATA_W / 2;
  localparam int DEPTH_W = ADDR_W - 2;

  state_t            state;
  logic              accept;
  logic              legal;
  logic [1:0]        eff_off;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic [2:0]        lat_f3;
  logic [1:0]        lat_off;
  logic              lat_ok;

  assign accept  = req_valid && req_ready;
  assign eff_off = align_off(req_funct3, req_addr[1:0]);

  always_comb begin
    legal = req_we ? store_legal(req_funct3) : load_legal(req_funct3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (misaligned(req_funct3, req_addr[1:0])) legal = 1'b0;
`endif
  end

  // Store data is replicated across all lanes; the byte enable picks the target.
  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << eff_off;
        wr_data = {4{req_wdata[LANE_W-1:0]}};
      end
      2'b01: begin
        wr_be   = eff_off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[HALF_W-1:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
  end

  // The array read is launched at the accepting edge, so a store committed on
  // the previous edge is already visible (read-after-write).
  dmem_array #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk   (clk),
    .we    (accept && req_we && legal),
    .be    (wr_be),
    .waddr (req_addr[ADDR_W-1:2]),
    .wdata (wr_data),
    .re    (accept && !req_we),
    .raddr (req_addr[ADDR_W-1:2]),
    .rdata (rd_word)
  );

  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] word);
    logic [LANE_W-1:0] b;
    logic [HALF_W-1:0] h;
    case (off)
      2'd0:    b = word[LANE_W-1:0];
      2'd1:    b = word[2*LANE_W-1:LANE_W];
      2'd2:    b = word[3*LANE_W-1:2*LANE_W];
      default: b = word[DATA_W-1:3*LANE_W];
    endcase
    h = off[1] ? word[DATA_W-1:HALF_W] : word[HALF_W-1:0];
    case (f3)
      F3_LB:   return {{(DATA_W-LANE_W){b[LANE_W-1]}}, b};
      F3_LH:   return {{(DATA_W-HALF_W){h[HALF_W-1]}}, h};
      F3_LBU:  return {{(DATA_W-LANE_W){1'b0}}, b};
      F3_LHU:  return {{(DATA_W-HALF_W){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
      lat_f3    <= 3'b000;
      lat_off   <= 2'b00;
      lat_ok    <= 1'b0;
    end else begin
      err       <= accept && !legal;
      rsp_valid <= 1'b0;
      case (state)
        READ: begin
          rsp_rdata <= lat_ok ? load_extend(lat_f3, lat_off, rd_word) : '0;
          rsp_valid <= 1'b1;
          state     <= RESP;
          req_ready <= 1'b1;
        end
        default: begin
          if (accept && !req_we) begin
            state     <= READ;
            req_ready <= 1'b0;
            lat_f3    <= req_funct3;
            lat_off   <= eff_off;
            lat_ok    <= legal;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  dmem_bridge #(.DATA_W(32), .ADDR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] d, input logic exp_err);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = d;
    check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check_eq({tag, "_novalid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] exp_data, input logic exp_err);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = a; req_wdata = '0;
    check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, "_read_ready"}, {31'd0, req_ready}, 32'd0);
    check_eq({tag, "_read_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, "_data"}, rsp_rdata, exp_data);
    check_eq({tag, "_resp_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);

    // Word store then load on the very next cycle (read-after-write).
    do_store("sw10", 3'b010, 9'h010, 32'hDEADBEEF, 1'b0);
    do_load("lw10", 3'b010, 9'h010, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check_eq("lw10_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("lw10_hold", rsp_rdata, 32'hDEADBEEF);

    // Byte/half stores and extension.
    do_store("sw20", 3'b010, 9'h020, 32'h00000000, 1'b0);
    do_store("sb21", 3'b000, 9'h021, 32'hFFFFFF80, 1'b0);
    do_load("lb21", 3'b000, 9'h021, 32'hFFFFFF80, 1'b0);
    do_load("lbu21", 3'b100, 9'h021, 32'h00000080, 1'b0);
    do_load("lh20", 3'b001, 9'h020, 32'hFFFF8000, 1'b0);
    do_load("lhu20", 3'b101, 9'h020, 32'h00008000, 1'b0);
    do_store("sh22", 3'b001, 9'h022, 32'hA5A51234, 1'b0);
    do_load("lw20", 3'b010, 9'h020, 32'h12348000, 1'b0);
    do_load("lbu23", 3'b100, 9'h023, 32'h00000012, 1'b0);

    // Back-to-back loads: second accepted in RESP of the first.
    @(negedge clk);
    do_load("b2b_a", 3'b010, 9'h010, 32'hDEADBEEF, 1'b0);
    do_load("b2b_b", 3'b101, 9'h022, 32'h00001234, 1'b0);
    @(negedge clk);
    check_eq("b2b_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("b2b_hold", rsp_rdata, 32'h00001234);

    // Misaligned accesses.
`ifdef DMEM_MISALIGN_TRAP_EN
    do_load("lw13", 3'b010, 9'h013, 32'h00000000, 1'b1);
    do_load("lh21", 3'b001, 9'h021, 32'h00000000, 1'b1);
    do_store("sw31_mis", 3'b010, 9'h021, 32'hFFFFFFFF, 1'b1);
    do_load("lw20_kept", 3'b010, 9'h020, 32'h12348000, 1'b0);
`else
    do_load("lw13", 3'b010, 9'h013, 32'hDEADBEEF, 1'b0);
    do_load("lh21", 3'b001, 9'h021, 32'hFFFF8000, 1'b0);
    do_store("sh23_mis", 3'b001, 9'h023, 32'h0000BEEF, 1'b0);
    do_load("lw20_al", 3'b010, 9'h020, 32'hBEEF8000, 1'b0);
`endif

    // Reset while a load is in READ: the response is dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h010;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rr_in_read", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rr_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rr_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rr_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    check_eq("rr_valid2", {31'd0, rsp_valid}, 32'd0);
    do_load("rr_lw10", 3'b010, 9'h010, 32'hDEADBEEF, 1'b0);

    // Illegal store funct3 leaves memory untouched; err is a single pulse.
    do_store("sw30", 3'b010, 9'h030, 32'h5555AAAA, 1'b0);
    do_store("s011", 3'b011, 9'h030, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check_eq("s011_err_pulse", {31'd0, err}, 32'd0);
    do_load("lw30", 3'b010, 9'h030, 32'h5555AAAA, 1'b0);
    do_load("l011", 3'b011, 9'h030, 32'h00000000, 1'b1);
    do_load("l110", 3'b110, 9'h030, 32'h00000000, 1'b1);
    do_load("lb30", 3'b000, 9'h030, 32'hFFFFFFAA, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
